// File: rtl/regfile_dump_if.sv
// regfile_dump_if
//   Bundles the control, register-file read and beat-stream signals of the
//   register dump engine.
//   master : the dump engine (drives busy/done/rf_addr and the beat stream)
//   slave  : the surrounding system (drives start/range, rf_data, m_ready)
//   Signals:
//     start, first_addr, last_addr : dump request and inclusive address range
//     busy, done                   : engine status
//     rf_addr, rf_data             : asynchronous register file read port
//     m_data, m_valid, m_ready     : beat stream payload and handshake
//     m_wlast, m_last              : end-of-word and end-of-dump markers
interface regfile_dump_if #(
  parameter int DW = 64,
  parameter int AW = 5,
  parameter int BW = 16
) ();
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic          busy;
  logic          done;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [BW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_wlast;
  logic          m_last;

  modport master (
    input  start, first_addr, last_addr, rf_data, m_ready,
    output busy, done, rf_addr, m_data, m_valid, m_wlast, m_last
  );

  modport slave (
    output start, first_addr, last_addr, rf_data, m_ready,
    input  busy, done, rf_addr, m_data, m_valid, m_wlast, m_last
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump
//   Walks an inclusive (wrapping) range of register addresses, snapshots each
//   DW-bit word in a LOAD cycle and streams it as DW/BW beats, LSB beat first.
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : asynchronous active-low reset
//     bus  : regfile_dump_if master modport (control, rf read port, stream)
module regfile_dump #(
  parameter int DW = 64,
  parameter int AW = 5,
  parameter int BW = 16
) (
  input logic            clk,
  input logic            rst,
  regfile_dump_if.master bus
);
  localparam int NB  = DW / BW;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q,    state_d;
  logic [AW-1:0]  rf_addr_q,  rf_addr_d;
  logic [AW-1:0]  end_addr_q, end_addr_d;
  logic [DW-1:0]  sh_q,       sh_d;
  logic [BCW-1:0] beat_q,     beat_d;

  logic send_s;
  logic hs_s;
  logic wlast_s;
  logic at_end_s;

  assign send_s   = (state_q == S_SEND);
  assign hs_s     = send_s && bus.m_ready;
  assign wlast_s  = (beat_q == LAST_BEAT);
  assign at_end_s = (rf_addr_q == end_addr_q);

  // Next-state logic for the dump sequencer and its datapath.
  always_comb begin
    state_d    = state_q;
    rf_addr_d  = rf_addr_q;
    end_addr_d = end_addr_q;
    sh_d       = sh_q;
    beat_d     = beat_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rf_addr_d  = bus.first_addr;
          end_addr_d = bus.last_addr;
          state_d    = S_LOAD;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_LOAD: begin
        // Snapshot: later writes to this address do not reach the beats.
        sh_d    = bus.rf_data;
        beat_d  = {BCW{1'b0}};
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs_s && !wlast_s) begin
          sh_d   = sh_q >> BW;
          beat_d = beat_q + BCW'(1);
        end else if (hs_s && at_end_s) begin
          state_d = S_DONE;
        end else if (hs_s) begin
          // Address wraps naturally modulo 2^AW.
          rf_addr_d = rf_addr_q + AW'(1);
          state_d   = S_LOAD;
        end else begin
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rf_addr_q  <= {AW{1'b0}};
      end_addr_q <= {AW{1'b0}};
      sh_q       <= {DW{1'b0}};
      beat_q     <= {BCW{1'b0}};
    end else begin
      state_q    <= state_d;
      rf_addr_q  <= rf_addr_d;
      end_addr_q <= end_addr_d;
      sh_q       <= sh_d;
      beat_q     <= beat_d;
    end
  end

  // Outputs decode directly from registered state so they clear
  // asynchronously with reset; stream fields are zero whenever not valid.
  assign bus.rf_addr = rf_addr_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.m_valid = send_s;
  assign bus.m_data  = send_s ? sh_q[BW-1:0] : {BW{1'b0}};
  assign bus.m_wlast = send_s && wlast_s;
  assign bus.m_last  = send_s && wlast_s && at_end_s;
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump
//   Directed bench for regfile_dump: a behavioural register file feeds the
//   read port, expected beats are queued when a dump starts and popped as the
//   stream handshakes.
module tb_regfile_dump;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int BW = 16;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_dump_if #(.DW(DW), .AW(AW), .BW(BW)) bus ();
  regfile_dump #(.DW(DW), .AW(AW), .BW(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] mem [0:31];
  assign bus.rf_data = mem[bus.rf_addr];

  typedef struct packed {
    logic [BW-1:0] d;
    logic          wl;
    logic          l;
  } beat_t;

  beat_t exp_q [$];
  beat_t mon_e;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int hs_count  = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int start_cyc = 0;
  logic          stall_pend = 1'b0;
  logic [BW-1:0] stall_data = '0;
  logic [15:0]   lfsr       = 16'hACE1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.m_valid) begin
        if (stall_pend) check("stall_stable", 64'(bus.m_data), 64'(stall_data));
        if (bus.m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(bus.m_data), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            mon_e = exp_q.pop_front();
            check("beat_data", 64'(bus.m_data), 64'(mon_e.d));
            check("beat_wlast", 64'(bus.m_wlast), 64'(mon_e.wl));
            check("beat_last", 64'(bus.m_last), 64'(mon_e.l));
          end
          hs_count++;
          stall_pend = 1'b0;
        end else begin
          stall_pend = 1'b1;
          stall_data = bus.m_data;
        end
      end else begin
        if (stall_pend) check("valid_held", 64'(bus.m_valid), 64'd1);
        check("idle_stream_zero", 64'({bus.m_data, bus.m_wlast, bus.m_last}), 64'd0);
        stall_pend = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic push_word(input logic [AW-1:0] a, input logic is_last);
    beat_t e;
    for (int b = 0; b < NB; b++) begin
      e.d  = mem[a][b*BW +: BW];
      e.wl = (b == NB - 1);
      e.l  = (b == NB - 1) && is_last;
      exp_q.push_back(e);
    end
  endtask

  // Call just after a rising edge; leaves the bench one cycle later (LOAD).
  task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
    logic [AW-1:0] a;
    logic [AW-1:0] span;
    int n;
    a    = f;
    span = l - f;
    n    = int'(span) + 1;
    for (int w = 0; w < n; w++) begin
      push_word(a, w == n - 1);
      a = a + 5'd1;
    end
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.start      = 1'b1;
    start_cyc      = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("rf_addr_first", 64'(bus.rf_addr), 64'(f));
    check("load_no_valid", 64'(bus.m_valid), 64'd0);
  endtask

  task automatic wait_done(input int max_cyc, input int exp_rel, input bit rnd);
    int prev;
    prev = done_cnt;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (rnd) begin
        bus.m_ready = lfsr[0];
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
      if (done_cnt != prev) break;
    end
    check("done_seen", 64'(done_cnt - prev), 64'd1);
    if (exp_rel >= 0) check("done_cycle", 64'(done_cyc - start_cyc), 64'(exp_rel));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    bus.m_ready = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] old3;
    int base;
    int dc;
    bus.start      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.m_ready    = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = {4{16'(i)}};
    mem[5] = 64'h0123_4567_89AB_CDEF;

    #12;
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_data", 64'(bus.m_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_rf_addr", 64'(bus.rf_addr), 64'd0);
    check("rst_marks", 64'({bus.m_wlast, bus.m_last}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single word.
    start_dump(5'd5, 5'd5);
    wait_done(20, 6, 1'b0);

    // Wrapping range 30..1.
    start_dump(5'd30, 5'd1);
    wait_done(40, 21, 1'b0);

    // Full 32-word dump under pseudo-random back-pressure.
    base = hs_count;
    start_dump(5'd0, 5'd31);
    wait_done(3000, -1, 1'b1);
    check("bp_beat_count", 64'(hs_count - base), 64'd128);

    // Start while busy is ignored; reg 3 snapshot taken at its LOAD.
    @(posedge clk); #1;
    old3 = mem[3];
    start_dump(5'd2, 5'd4);
    repeat (7) begin @(posedge clk); #1; end
    check("send_reg3_valid", 64'(bus.m_valid), 64'd1);
    check("send_reg3_addr", 64'(bus.rf_addr), 64'd3);
    bus.first_addr = 5'd10;
    bus.last_addr  = 5'd10;
    bus.start      = 1'b1;
    mem[3]         = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(30, 16, 1'b0);
    @(posedge clk); #1;
    check("busy_start_ignored", 64'(bus.busy), 64'd0);
    check("old3_kept", 64'(old3 != mem[3]), 64'd1);
    start_dump(5'd3, 5'd3);
    wait_done(20, 6, 1'b0);

    // Reset on beat 2 of word 1.
    @(posedge clk); #1;
    base = hs_count;
    start_dump(5'd0, 5'd3);
    for (int i = 0; i < 40; i++) begin
      if (hs_count >= base + 6) break;
      @(posedge clk); #1;
    end
    check("reached_word1_beat2", 64'(hs_count - base), 64'd6);
    #2;
    rst = 1'b0;
    #1;
    check("arst_m_valid", 64'(bus.m_valid), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_rf_addr", 64'(bus.rf_addr), 64'd0);
    exp_q.delete();
    dc = done_cnt;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("no_done_after_abort", 64'(done_cnt - dc), 64'd0);
    check("idle_after_abort", 64'(bus.busy), 64'd0);
    start_dump(5'd7, 5'd7);
    wait_done(20, 6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Read-side streaming engine for the 64-bit, 32-entry register file. On a start request it walks a range of register addresses through one asynchronous read port, captures each word and emits it as a valid/ready stream of narrower beats, LSB beat first. It sits between the register file read port and a debug or readback channel, and is the consumer-side counterpart to the write-side traffic generator.

## Interface
Parameters:
- `DW`, 64, register word width; must be a multiple of `BW`.
- `AW`, 5, register address width; depth is 2^AW.
- `BW`, 16, stream beat width. `NB = DW/BW` beats per word (default 4).

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `first_addr`  in  AW  first register to dump; sampled with `start`.
- `last_addr`  in  AW  final register to dump; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse after the final beat's handshake.
- `rf_addr`  out  AW  register file read address; registered.
- `rf_data`  in  DW  register file read data; combinational from `rf_addr`.
- `m_data`  out  BW  beat payload.
- `m_valid`  out  1  beat valid.
- `m_ready`  in  1  sink ready; a handshake occurs when `m_valid` and `m_ready` are both high on a rising edge.
- `m_wlast`  out  1  high on the last beat (beat NB-1) of each word.
- `m_last`  out  1  high on the last beat of the last word.

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - `start`=1 registers `rf_addr<=first_addr` and `end_addr<=last_addr`, then goes to LOAD.
  - `start`=0 stays in IDLE.
- LOAD: captures `rf_data` into shift register `sh`, sets `beat<=0`, then goes to SEND. `m_valid`=0 in this state.
- SEND:
  - `m_valid`=1 and `m_data=sh[BW-1:0]`.
  - `m_wlast=(beat==NB-1)`; `m_last=m_wlast && (rf_addr==end_addr)`.
  - On handshake with `beat<NB-1`: `sh<=sh>>BW` and `beat<=beat+1`.
  - On handshake with `beat==NB-1`: go to DONE if `rf_addr==end_addr`; otherwise `rf_addr<=rf_addr+1` (mod 2^AW) and go to LOAD.
  - Without a handshake, all outputs and state hold.
- DONE: `done`=1 for one cycle, then IDLE. `rf_addr` keeps the last address.
- Word count is `((last_addr-first_addr) mod 2^AW)+1`:
  - `first_addr==last_addr` dumps exactly 1 word.
  - `last_addr<first_addr` wraps from 31 to 0 and continues.
  - Dumping all 32 words requires `last_addr=first_addr-1`.
- `start` is ignored while `busy`=1, and in the DONE cycle.
- Each word is snapshotted in its LOAD cycle. Register file writes to that address after LOAD are not reflected in the beats being sent. A write to a later address before its LOAD is reflected.
- `m_data`, `m_wlast` and `m_last` are driven 0 whenever `m_valid`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_data`=0, `m_wlast`=0, `m_last`=0, `rf_addr`=0, state IDLE.
- Reset asserted mid-dump aborts immediately: `m_valid` drops asynchronously and no `done` is produced.
- Cycle timeline, with `start` high at cycle 0:
  - Cycle 1: LOAD, `busy`=1.
  - Cycle 2: first beat valid.
- With `m_ready` held high, each word takes NB+1 cycles (1 LOAD cycle plus NB beats). Default is 5 cycles per word, i.e. 80% stream utilisation.
- `done` is asserted in the cycle after the final handshake. For W words with no back-pressure, `done` is in cycle `1+W*(NB+1)`. Default 1-word dump: `done` in cycle 6.
- Back-pressure: `m_data` must be stable while `m_valid`=1 and `m_ready`=0. `m_valid` never drops without a handshake.
- `rf_addr` changes only on the edge entering LOAD or on `start` acceptance. The register file read path must settle within one clock.

## Test plan
- Single word, default parameters:
  - Stimulus: preload reg 5 = 0x0123_4567_89AB_CDEF, `first=last=5`, `m_ready`=1.
  - Response: beats 0xCDEF, 0x89AB, 0x4567, 0x0123. `m_wlast` and `m_last` high on beat 4 only. `done` in cycle 6.
- Wrap range:
  - Stimulus: `first=30`, `last=1`, each reg holds its index in all four 16-bit lanes.
  - Response: words from regs 30, 31, 0, 1 (16 beats). `m_wlast` high on beats 4, 8, 12, 16; `m_last` high on beat 16 only. `done` in cycle 21.
- Back-pressure:
  - Stimulus: toggle `m_ready` pseudo-randomly from an LFSR during a 32-word dump (`first=0`, `last=31`).
  - Response: 128 beats received in order, with `m_data` stable whenever stalled. No beat dropped or duplicated.
- Busy start and snapshot:
  - Stimulus: pulse `start` while in SEND; write reg 3 during its SEND phase.
  - Response: the second `start` is ignored. The old reg 3 value is streamed, and the new value appears only in the next dump.
- Reset mid-dump:
  - Stimulus: assert `rst`=0 on beat 2 of word 1, release, then issue `start` with `first=last=7`.
  - Response: `m_valid`, `busy` and `rf_addr` go to 0 asynchronously, with no `done`. The new dump then completes normally with 4 beats.
